// File: rtl/p2_paddle_ctrl.sv
// Player-2 paddle controller: synchronises and debounces the up/down buttons and
// steps the paddle on each frame tick while in play, clamped to the playfield.
module p2_paddle_ctrl #(
  parameter int Y_W       = 10,
  parameter int FIELD_H   = 480,
  parameter int PAD_H     = 64,
  parameter int STEP      = 4,
  parameter int TICK_DIV  = 833333,
  parameter int DB_CYCLES = 500000
) (
  input  logic           sys_clock,
  input  logic           reset,
  input  logic           start,
  input  logic           reset_game,
  input  logic           btn_up,
  input  logic           btn_dn,
  output logic [Y_W-1:0] p2y,
  output logic           moving,
  output logic           at_top,
  output logic           at_bot
);

  localparam int MAXY   = FIELD_H - PAD_H;
  localparam int CENTRE = MAXY / 2;
  localparam logic [Y_W-1:0] MAXY_Y   = Y_W'(MAXY);
  localparam logic [Y_W-1:0] CENTRE_Y = Y_W'(CENTRE);
  localparam logic [Y_W-1:0] STEP_Y   = Y_W'(STEP);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

  typedef enum logic {IDLE, PLAY} state_e;

  logic [1:0] rawBtn;
  logic [1:0] dbLvl;

  assign rawBtn = {btn_dn, btn_up};

  // Bit 0 is the up button, bit 1 the down button; each gets its own sync + debounce.
  for (genvar g = 0; g < 2; g++) begin : gDb
    logic          meta_q, sync_q, lvl_q, lvl_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync_q != lvl_q) begin
        if (cnt_q == DB_LAST) lvl_d = sync_q;
        else                  cnt_d = cnt_q + DW'(1);
      end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
        lvl_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        meta_q <= rawBtn[g];
        sync_q <= meta_q;
        lvl_q  <= lvl_d;
        cnt_q  <= cnt_d;
      end
    end

    assign dbLvl[g] = lvl_q;
  end

  state_e         state_q, state_d;
  logic [Y_W-1:0] p2y_q, p2y_d;
  logic [TW-1:0]  tickCnt_q, tickCnt_d;
  logic           moving_q, moving_d;
  logic           tick;
  logic [Y_W-1:0] upPos, dnPos, movePos;
  logic [Y_W:0]   downSum;

  // Clamped candidate positions; the down sum carries an extra bit so it cannot wrap.
  assign upPos   = (p2y_q < STEP_Y) ? '0 : p2y_q - STEP_Y;
  assign downSum = {1'b0, p2y_q} + {1'b0, STEP_Y};
  assign dnPos   = (downSum > {1'b0, MAXY_Y}) ? MAXY_Y : downSum[Y_W-1:0];
  assign tick    = (state_q == PLAY) && (tickCnt_q == TICK_LAST);

  always_comb begin
    case (dbLvl)
      2'b01:   movePos = upPos;
      2'b10:   movePos = dnPos;
      default: movePos = p2y_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    p2y_d     = p2y_q;
    tickCnt_d = tickCnt_q;
    moving_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tickCnt_d = '0;
        if (reset_game) p2y_d   = CENTRE_Y;
        else if (start) state_d = PLAY;
      end
      PLAY: begin
        // A recentre request overrides any tick landing on the same edge.
        if (reset_game) begin
          state_d   = IDLE;
          p2y_d     = CENTRE_Y;
          tickCnt_d = '0;
        end else begin
          tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
          if (tick) begin
            p2y_d    = movePos;
            moving_d = (movePos != p2y_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      p2y_q     <= CENTRE_Y;
      tickCnt_q <= '0;
      moving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      p2y_q     <= p2y_d;
      tickCnt_q <= tickCnt_d;
      moving_q  <= moving_d;
    end
  end

  assign p2y    = p2y_q;
  assign moving = moving_q;
  assign at_top = (p2y_q == '0);
  assign at_bot = (p2y_q == MAXY_Y);

endmodule

// File: tb/tb_p2_paddle_ctrl.sv
// Scoreboard bench for p2_paddle_ctrl: a behavioural model predicts every cycle's
// outputs into a queue, and a monitor pops and compares after each rising edge.
module tb_p2_paddle_ctrl;

  localparam int Y_W       = 10;
  localparam int FIELD_H   = 480;
  localparam int PAD_H     = 64;
  localparam int STEP      = 4;
  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;
  localparam int MAXY      = FIELD_H - PAD_H;
  localparam int CENTRE    = MAXY / 2;

  logic           sys_clock  = 1'b0;
  logic           reset      = 1'b0;
  logic           start      = 1'b0;
  logic           reset_game = 1'b0;
  logic           btn_up     = 1'b0;
  logic           btn_dn     = 1'b0;
  logic [Y_W-1:0] p2y;
  logic           moving;
  logic           at_top;
  logic           at_bot;

  p2_paddle_ctrl #(
    .Y_W(Y_W), .FIELD_H(FIELD_H), .PAD_H(PAD_H), .STEP(STEP),
    .TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)
  ) dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .start     (start),
    .reset_game(reset_game),
    .btn_up    (btn_up),
    .btn_dn    (btn_dn),
    .p2y       (p2y),
    .moving    (moving),
    .at_top    (at_top),
    .at_bot    (at_bot)
  );

  always #5 sys_clock = ~sys_clock;

  typedef struct {
    int y;
    bit mv;
  } exp_t;

  exp_t expQ[$];
  int   vecCount = 0;
  int   errCount = 0;

  // Model state: position as a plain integer, play flag with elapsed play cycles,
  // raw button history and a window of recent synchronised samples per button.
  int mY;
  bit mMoving;
  bit mPlaying;
  int mPlayCycles;
  bit mLvlUp, mLvlDn;
  bit rawUp[$], rawDn[$];
  bit syncUp[$], syncDn[$];

  function automatic void modelReset();
    mY          = CENTRE;
    mMoving     = 1'b0;
    mPlaying    = 1'b0;
    mPlayCycles = 0;
    mLvlUp      = 1'b0;
    mLvlDn      = 1'b0;
    rawUp.delete(); rawDn.delete();
    syncUp.delete(); syncDn.delete();
    repeat (2) begin
      rawUp.push_back(1'b0);
      rawDn.push_back(1'b0);
    end
  endfunction

  // A button level flips only once the last DB_CYCLES synchronised samples all disagree with it.
  function automatic bit settled(input bit h[$], input bit lvl);
    if (h.size() < DB_CYCLES) return lvl;
    foreach (h[i]) if (h[i] == lvl) return lvl;
    return !lvl;
  endfunction

  function automatic void modelStep(input bit r, input bit up, input bit dn,
                                    input bit st, input bit rg);
    bit sU, sD, tick;
    int newY;
    if (!r) begin
      modelReset();
      return;
    end
    sU = rawUp[rawUp.size()-2];
    sD = rawDn[rawDn.size()-2];
    rawUp.push_back(up); void'(rawUp.pop_front());
    rawDn.push_back(dn); void'(rawDn.pop_front());

    mMoving = 1'b0;
    if (rg) begin
      mPlaying = 1'b0;
      mY       = CENTRE;
    end else if (!mPlaying) begin
      if (st) begin
        mPlaying    = 1'b1;
        mPlayCycles = 0;
      end
    end else begin
      tick = ((mPlayCycles % TICK_DIV) == TICK_DIV - 1);
      mPlayCycles++;
      if (tick) begin
        newY = mY;
        if (mLvlUp && !mLvlDn)      newY = (mY - STEP < 0) ? 0 : mY - STEP;
        else if (mLvlDn && !mLvlUp) newY = (mY + STEP > MAXY) ? MAXY : mY + STEP;
        mMoving = (newY != mY);
        mY      = newY;
      end
    end

    syncUp.push_back(sU); if (syncUp.size() > DB_CYCLES) void'(syncUp.pop_front());
    syncDn.push_back(sD); if (syncDn.size() > DB_CYCLES) void'(syncDn.pop_front());
    mLvlUp = settled(syncUp, mLvlUp);
    mLvlDn = settled(syncDn, mLvlDn);
  endfunction

  function automatic void pushExpected();
    exp_t e;
    e.y  = mY;
    e.mv = mMoving;
    expQ.push_back(e);
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what the next rising edge should produce.
  task automatic applyStimulus(input bit r, input bit up, input bit dn,
                               input bit st, input bit rg);
    @(negedge sys_clock);
    reset      = r;
    btn_up     = up;
    btn_dn     = dn;
    start      = st;
    reset_game = rg;
    modelStep(r, up, dn, st, rg);
    pushExpected();
  endtask

  task automatic checkOutput(input string name, input int act, input int req);
    vecCount++;
    if (act != req) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drop reset partway through a cycle and confirm the paddle recentres with no clock edge.
  task automatic asyncResetCheck();
    @(negedge sys_clock);
    btn_up = 1'b0; btn_dn = 1'b0; start = 1'b0; reset_game = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async reset p2y", int'(p2y), CENTRE);
    checkOutput("async reset moving", int'(moving), 0);
    modelReset();
    pushExpected();
  endtask

  // Monitor: every rising edge with a pending expectation gets compared one step later.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clock);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        vecCount++;
        if (int'(p2y) != e.y || moving != e.mv ||
            at_top != (e.y == 0) || at_bot != (e.y == MAXY)) begin
          errCount++;
          $display("[TB] FAIL scoreboard @%0t: p2y=%0d moving=%0b at_top=%0b at_bot=%0b, expected p2y=%0d moving=%0b at_top=%0b at_bot=%0b",
                   $time, p2y, moving, at_top, at_bot, e.y, e.mv, e.y == 0, e.y == MAXY);
        end
      end
    end
  end

  initial begin
    int snapY;
    int guard;
    int holdLeft;
    bit ru, rd, rs, rg;

    modelReset();

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset p2y", int'(p2y), CENTRE);
    checkOutput("reset moving", int'(moving), 0);
    checkOutput("reset at_top", int'(at_top), 0);
    checkOutput("reset at_bot", int'(at_bot), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Down held while idle must not move the paddle.
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("idle hold p2y", int'(p2y), CENTRE);

    // Start and drive to the bottom clamp, then keep pushing.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (260) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bottom clamp p2y", int'(p2y), MAXY);
    checkOutput("bottom clamp at_bot", int'(at_bot), 1);

    // Up to the top clamp.
    repeat (460) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("top clamp p2y", int'(p2y), 0);
    checkOutput("top clamp at_top", int'(at_top), 1);

    // A two-cycle press is too short to be accepted.
    repeat (10) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2)  applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("short pulse p2y", int'(p2y), 0);

    // Move off the top, then hold both buttons: no motion once both are accepted.
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    snapY = mY;
    repeat (40) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both held p2y", int'(p2y), snapY);

    // Walk to 300 and recentre with reset_game; held buttons must then do nothing.
    guard = 0;
    while (mY < 300 && guard < 500) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    checkOutput("reached 300", int'(mY >= 300), 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_game p2y", int'(p2y), CENTRE);

    // Start and reset_game together: stay idle.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (16) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("start+reset_game p2y", int'(p2y), CENTRE);

    // Play up to about row 100, then drop reset between edges.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (mY > 100 && guard < 500) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    asyncResetCheck();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised phase: held button patterns of random length with occasional start/recentre.
    holdLeft = 0;
    ru = 1'b0;
    rd = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (holdLeft == 0) begin
        ru       = 1'($urandom_range(0, 1));
        rd       = 1'($urandom_range(0, 1));
        holdLeft = int'($urandom_range(1, 12));
      end
      holdLeft--;
      rs = ($urandom_range(0, 19) == 0);
      rg = ($urandom_range(0, 59) == 0);
      applyStimulus(1'b1, ru, rd, rs, rg);
    end

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge sys_clock);
      guard++;
    end
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
